// File: rtl/mem_access_unit.sv
// Load/store access unit: turns a combinational exec memory request into a
// req/ack data-bus transaction, with alignment check, timeout and flush drain.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mau_read_en_in,
  input  logic        mau_write_en_in,
  input  logic [31:0] mau_addr_in,
  input  logic [31:0] mau_wdata_in,
  input  logic [3:0]  mau_byte_num_in,
  output logic        mau_valid_out,
  output logic [31:0] mau_rdata_out,
  output logic        mau_err_out,
  output logic        bus_req_out,
  output logic        bus_we_out,
  output logic [31:0] bus_addr_out,
  output logic [31:0] bus_wdata_out,
  output logic [3:0]  bus_be_out,
  input  logic        bus_ack_in,
  input  logic [31:0] bus_rdata_in
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2, DRAIN = 2'd3} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wdrawn_q, wdrawn_d;
  logic [1:0]  off_q, off_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] baddr_q, baddr_d;
  logic [31:0] bwdata_q, bwdata_d;
  logic [3:0]  be_q, be_d;
  logic        any_req_s;
  logic        withdraw_s;

  // Unsupported size masks count as misaligned, so exec always gets an answer.
  function automatic logic misaligned_f(input logic [3:0] mask, input logic [1:0] off);
    case (mask)
      4'b0001: misaligned_f = 1'b0;
      4'b0011: misaligned_f = off[0];
      4'b1111: misaligned_f = |off;
      default: misaligned_f = 1'b1;
    endcase
  endfunction

  assign any_req_s  = mau_read_en_in | mau_write_en_in;
  assign withdraw_s = wdrawn_q | ~any_req_s;

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wdrawn_d = wdrawn_q;
    off_d    = off_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    req_d    = req_q;
    we_d     = we_q;
    baddr_d  = baddr_q;
    bwdata_d = bwdata_q;
    be_d     = be_q;
    case (state_q)
      IDLE: begin
        if (!any_req_s) begin
          state_d = IDLE;
        end else if (misaligned_f(mau_byte_num_in, mau_addr_in[1:0])) begin
          state_d = DONE;
          valid_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = ERR_DATA;
        end else begin
          state_d  = REQ;
          req_d    = 1'b1;
          we_d     = ~mau_read_en_in;
          baddr_d  = {mau_addr_in[31:2], 2'b00};
          be_d     = 4'(mau_byte_num_in << mau_addr_in[1:0]);
          bwdata_d = mau_wdata_in << {mau_addr_in[1:0], 3'b000};
          off_d    = mau_addr_in[1:0];
          cnt_d    = 8'd0;
          wdrawn_d = 1'b0;
        end
      end
      REQ: begin
        if (bus_ack_in) begin
          req_d = 1'b0;
          if (withdraw_s) begin
            state_d = DRAIN;
          end else begin
            state_d = DONE;
            valid_d = 1'b1;
            rdata_d = we_q ? 32'h0 : (bus_rdata_in >> {off_q, 3'b000});
          end
        end else if (cnt_q == TMO_LAST) begin
          req_d   = 1'b0;
          state_d = DONE;
          valid_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = ERR_DATA;
        end else begin
          cnt_d    = cnt_q + 8'd1;
          wdrawn_d = withdraw_s;
        end
      end
      DONE:    state_d = IDLE;
      DRAIN:   state_d = IDLE;
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      wdrawn_q <= 1'b0;
      off_q    <= 2'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      baddr_q  <= 32'h0;
      bwdata_q <= 32'h0;
      be_q     <= 4'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wdrawn_q <= wdrawn_d;
      off_q    <= off_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      req_q    <= req_d;
      we_q     <= we_d;
      baddr_q  <= baddr_d;
      bwdata_q <= bwdata_d;
      be_q     <= be_d;
    end
  end

  assign mau_valid_out = valid_q;
  assign mau_err_out   = err_q;
  assign mau_rdata_out = rdata_q;
  assign bus_req_out   = req_q;
  assign bus_we_out    = we_q;
  assign bus_addr_out  = baddr_q;
  assign bus_wdata_out = bwdata_q;
  assign bus_be_out    = be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of single transactions plus
// hand-written timeout, flush-drain and reset sequences.
module tb_mem_access_unit;

  localparam logic [31:0] ERR = 32'hBADC0FFE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [3:0]  bnum = 4'h0;
  logic        valid, err, req, we, ack = 1'b0;
  logic [31:0] rdata, baddr, bwdata, ack_data = 32'h0;
  logic [3:0]  be;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(8), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst_n(rst_n),
    .mau_read_en_in(rd), .mau_write_en_in(wr), .mau_addr_in(addr),
    .mau_wdata_in(wdata), .mau_byte_num_in(bnum),
    .mau_valid_out(valid), .mau_rdata_out(rdata), .mau_err_out(err),
    .bus_req_out(req), .bus_we_out(we), .bus_addr_out(baddr),
    .bus_wdata_out(bwdata), .bus_be_out(be),
    .bus_ack_in(ack), .bus_rdata_in(ack_data)
  );

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  bnum;
    int          waits;
    logic [31:0] ack_data;
    logic        mis;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    rd = v.rd; wr = v.wr; addr = v.addr; wdata = v.wdata; bnum = v.bnum;
    tick();
    if (v.mis) begin
      rd = 1'b0; wr = 1'b0;
      chk({t, " mis valid"}, 32'(valid), 32'd1);
      chk({t, " mis err"}, 32'(err), 32'd1);
      chk({t, " mis rdata"}, rdata, ERR);
      chk({t, " mis no req"}, 32'(req), 32'd0);
    end else begin
      chk({t, " req"}, 32'(req), 32'd1);
      chk({t, " addr"}, baddr, v.e_addr);
      chk({t, " be"}, 32'(be), 32'(v.e_be));
      chk({t, " we"}, 32'(we), 32'(v.e_we));
      chk({t, " wdata"}, bwdata, v.e_wdata);
      for (int i = 0; i < v.waits; i++) begin
        tick();
        chk({t, " wait req"}, 32'(req), 32'd1);
        chk({t, " wait valid"}, 32'(valid), 32'd0);
      end
      ack = 1'b1; ack_data = v.ack_data;
      tick();
      ack = 1'b0; rd = 1'b0; wr = 1'b0;
      chk({t, " valid"}, 32'(valid), 32'd1);
      chk({t, " err"}, 32'(err), 32'd0);
      chk({t, " rdata"}, rdata, v.e_rdata);
      chk({t, " req drop"}, 32'(req), 32'd0);
    end
    tick();
    chk({t, " one-cycle valid"}, 32'(valid), 32'd0);
  endtask

  initial begin
    int cnt;
    bit seen;
    //         rd    wr    addr          wdata         bnum  w  ack_data      mis   we    be     e_addr        e_wdata       e_rdata
    vecs[0] = '{1'b1, 1'b0, 32'h00000100, 32'h00000000, 4'hF, 0, 32'hDEADBEEF, 1'b0, 1'b0, 4'hF, 32'h00000100, 32'h00000000, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b0, 32'h00000103, 32'h00000000, 4'h1, 3, 32'hAB000000, 1'b0, 1'b0, 4'h8, 32'h00000100, 32'h00000000, 32'h000000AB};
    vecs[2] = '{1'b0, 1'b1, 32'h00000202, 32'h00001234, 4'h3, 1, 32'h55555555, 1'b0, 1'b1, 4'hC, 32'h00000200, 32'h12340000, 32'h00000000};
    vecs[3] = '{1'b1, 1'b0, 32'h00000101, 32'h00000000, 4'hF, 0, 32'h00000000, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, ERR};
    vecs[4] = '{1'b1, 1'b0, 32'h00000102, 32'h00000000, 4'h3, 0, 32'hCAFE0000, 1'b0, 1'b0, 4'hC, 32'h00000100, 32'h00000000, 32'h0000CAFE};
    vecs[5] = '{1'b0, 1'b1, 32'h00000101, 32'h0000005A, 4'h1, 2, 32'h00000000, 1'b0, 1'b1, 4'h2, 32'h00000100, 32'h00005A00, 32'h00000000};
    vecs[6] = '{1'b1, 1'b0, 32'h00000103, 32'h00000000, 4'h3, 0, 32'h00000000, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, ERR};
    vecs[7] = '{1'b1, 1'b0, 32'h00000000, 32'h00000000, 4'h7, 0, 32'h00000000, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, ERR};
    vecs[8] = '{1'b1, 1'b1, 32'h00000010, 32'hFFFFFFFF, 4'hF, 0, 32'h11223344, 1'b0, 1'b0, 4'hF, 32'h00000010, 32'hFFFFFFFF, 32'h11223344};

    #1;
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset req", 32'(req), 32'd0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset be", 32'(be), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Ack while idle must be ignored.
    ack = 1'b1; ack_data = 32'h12345678;
    tick();
    ack = 1'b0;
    chk("idle ack valid", 32'(valid), 32'd0);
    chk("idle ack req", 32'(req), 32'd0);
    tick();

    // Timeout: no ack, request held TIMEOUT_CYCLES cycles.
    rd = 1'b1; addr = 32'h400; bnum = 4'hF; wdata = 32'h0;
    tick();
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (valid) begin
        seen = 1'b1;
        chk("tmo err", 32'(err), 32'd1);
        chk("tmo rdata", rdata, ERR);
        chk("tmo req low", 32'(req), 32'd0);
      end else begin
        if (req) cnt++;
        tick();
      end
    end
    chk("tmo valid seen", 32'(seen), 32'd1);
    chk("tmo req cycles", 32'(cnt), 32'd8);
    rd = 1'b0;
    tick();

    // Flush: read_en drops a cycle after bus_req, ack two cycles later.
    rd = 1'b1; addr = 32'h300; bnum = 4'hF;
    tick();
    chk("flush req", 32'(req), 32'd1);
    tick();
    rd = 1'b0;
    tick();
    chk("flush req held", 32'(req), 32'd1);
    ack = 1'b1; ack_data = 32'h0BADF00D;
    cnt = 0;
    tick();
    ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (valid) cnt++;
      tick();
    end
    chk("flush no valid", 32'(cnt), 32'd0);
    chk("flush req dropped", 32'(req), 32'd0);
    run_vec(vecs[0], 100);

    // Reset mid-request.
    rd = 1'b1; addr = 32'h104; bnum = 4'hF;
    tick();
    chk("prerst req", 32'(req), 32'd1);
    #2 rst_n = 1'b0; ack = 1'b1; ack_data = 32'hFFFFFFFF;
    #1;
    chk("rst req", 32'(req), 32'd0);
    chk("rst addr", baddr, 32'h0);
    chk("rst be", 32'(be), 32'd0);
    chk("rst valid", 32'(valid), 32'd0);
    tick();
    chk("rst ack ignored", 32'(valid), 32'd0);
    ack = 1'b0; rd = 1'b0;
    rst_n = 1'b1;
    tick();
    run_vec(vecs[0], 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
